// File: rtl/uart_rx_frame_check.sv
// Oversampled UART RX frame checker: 3-sample majority vote per bit, start-glitch,
// optional parity (compile with RX_PARITY_CHK_EN) and one/two stop-bit checks.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  strt_glitch,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

`ifdef RX_PARITY_CHK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_stop2;
    logic                  r_stop_cnt;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_stp_flag;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_strt_glitch;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_busy;

    logic [PRESCALE_W-1:0] w_prescale_clamp;
    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_next_edge;
    logic                  w_last_edge;
    logic                  w_at_s0;
    logic                  w_at_s1;
    logic                  w_at_dec;
    logic                  w_vote;
    logic                  w_par_bad;

    assign w_prescale_clamp = (prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : prescale;
    assign w_mid            = r_prescale >> 1;
    assign w_last_edge      = (r_edge_cnt == r_prescale - 1'b1);
    assign w_next_edge      = w_last_edge ? '0 : r_edge_cnt + 1'b1;
    assign w_at_s0          = (r_edge_cnt == w_mid - 1'b1);
    assign w_at_s1          = (r_edge_cnt == w_mid);
    assign w_at_dec         = (r_edge_cnt == w_mid + 1'b1);
    // third sample is the live line at the decision edge
    assign w_vote           = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);

`ifdef RX_PARITY_CHK_EN
    logic r_par_en;
    logic r_par_typ;
    logic r_par_flag;
    logic w_par_exp;
    assign w_par_exp = (^r_shift) ^ r_par_typ;
    assign w_par_bad = r_par_flag;
`else
    logic w_unused_par;
    assign w_unused_par = PAR_EN ^ PAR_TYP;
    assign w_par_bad    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        r_data_valid  <= 1'b0;
        r_strt_glitch <= 1'b0;
        r_par_err     <= 1'b0;
        r_stp_err     <= 1'b0;
        if (RST) begin
            r_state    <= IDLE;
            r_edge_cnt <= '0;
            r_prescale <= '0;
            r_bit_cnt  <= '0;
            r_stop2    <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_stp_flag <= 1'b0;
            r_shift    <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
`ifdef RX_PARITY_CHK_EN
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_flag <= 1'b0;
`endif
        end else begin
            if (r_state != IDLE && w_at_s0) r_s0 <= RX_IN;
            if (r_state != IDLE && w_at_s1) r_s1 <= RX_IN;
            case (r_state)
                IDLE: begin
                    if (!RX_IN) begin
                        r_state    <= START;
                        r_edge_cnt <= PRESCALE_W'(1);
                        r_prescale <= w_prescale_clamp;
                        r_stop2    <= STOP2;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_stp_flag <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef RX_PARITY_CHK_EN
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_flag <= 1'b0;
`endif
                    end
                end
                START: begin
                    r_edge_cnt <= w_next_edge;
                    if (w_at_dec && w_vote) begin
                        r_strt_glitch <= 1'b1;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_edge_cnt    <= '0;
                    end else if (w_last_edge) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_edge_cnt <= w_next_edge;
                    if (w_at_dec) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                    if (w_last_edge) begin
                        if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
`ifdef RX_PARITY_CHK_EN
                            r_state   <= r_par_en ? PARITY : STOP;
`else
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef RX_PARITY_CHK_EN
                PARITY: begin
                    r_edge_cnt <= w_next_edge;
                    if (w_at_dec && (w_vote != w_par_exp)) r_par_flag <= 1'b1;
                    if (w_last_edge) r_state <= STOP;
                end
`endif
                STOP: begin
                    r_edge_cnt <= w_next_edge;
                    if (w_last_edge) r_stop_cnt <= 1'b1;
                    if (w_at_dec) begin
                        // last stop bit: leave early so a back-to-back start is not missed
                        if (r_stop_cnt == r_stop2) begin
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                            r_edge_cnt <= '0;
                            if (w_par_bad || r_stp_flag || !w_vote) begin
                                r_par_err <= w_par_bad;
                                r_stp_err <= r_stp_flag | ~w_vote;
                            end else begin
                                r_data_valid <= 1'b1;
                                r_data_out   <= r_shift;
                            end
                        end else if (!w_vote) begin
                            r_stp_flag <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign strt_glitch = r_strt_glitch;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign busy        = r_busy;

endmodule
